entrada_teclado: RTL and testbench

- Upstream front-end for `Cajero`: converts raw keypad events into the ATM's input handshakes.
- In the PIN phase it forwards each digit as `DIGITO`/`DIGITO_STB`.
- In the amount phase it accumulates decimal keystrokes into a binary `MONTO`, latches `TIPO_TRANS`, and issues `MONTO_STB` on ENTER.
- It tracks `PIN_INCORRECTO`/`BLOQUEO` from `Cajero` so keypad phase and ATM state stay aligned.

---
 rtl/cajero_pkg.sv | 34 +++
 rtl/acum_decimal.sv | 70 +++++++
 rtl/entrada_teclado.sv | 170 +++++++++++++++++
 tb/tb_entrada_teclado.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cajero_pkg.sv
// Shared definitions for the ATM keypad front-end and Cajero: key codes,
// keypad-phase state encoding, accumulator op codes and the MONTO width.
package cajero_pkg;

  localparam int unsigned MONTO_W = 32;
  localparam int unsigned TECLA_W = 4;

  localparam logic [TECLA_W-1:0] TECLA_ENTER  = 4'hA;
  localparam logic [TECLA_W-1:0] TECLA_CLEAR  = 4'hB;
  localparam logic [TECLA_W-1:0] TECLA_DEP    = 4'hC;
  localparam logic [TECLA_W-1:0] TECLA_RET    = 4'hD;
  localparam logic [TECLA_W-1:0] TECLA_BORRAR = 4'hE;

  typedef enum logic [2:0] {
    ST_ESPERA = 3'd0,
    ST_PIN    = 3'd1,
    ST_MONTO  = 3'd2,
    ST_HECHO  = 3'd3,
    ST_BLOQ   = 3'd4
  } estado_e;

  typedef enum logic [1:0] {
    ACC_NOP = 2'd0,
    ACC_CLR = 2'd1,
    ACC_ADD = 2'd2,
    ACC_DEL = 2'd3
  } acc_op_e;

  // Keys 0x0..0x9 are decimal digits.
  function automatic logic es_digito(input logic [TECLA_W-1:0] t);
    return t <= TECLA_W'(9);
  endfunction

endpackage

// File: rtl/acum_decimal.sv
// Decimal amount accumulator: holds the binary value and its digit count.
// Ops (applied when en=1): clear, append digit (acc*10+d, only below
// MAX_DIGITOS), backspace (acc/10, only with ENTRADA_BORRADO_EN defined).
// Ports: clk, rst (sync, active-high), en, op, digito -> acc, sat, vacio.
// Macro: ENTRADA_BORRADO_EN enables the backspace divider.
module acum_decimal
  import cajero_pkg::*;
#(
  parameter int unsigned MAX_DIGITOS = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  acc_op_e            op,
  input  logic [TECLA_W-1:0] digito,
  output logic [MONTO_W-1:0] acc,
  output logic               sat,
  output logic               vacio
);

  localparam int unsigned CNT_W = $clog2(MAX_DIGITOS + 1);

  logic [MONTO_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Next-state for value and digit count.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (en) begin
      case (op)
        ACC_CLR: begin
          acc_d = '0;
          cnt_d = '0;
        end
        ACC_ADD: begin
          // acc*10 as two shifts; 9 digits always fit in 32 bits.
          if (cnt_q < CNT_W'(MAX_DIGITOS)) begin
            acc_d = (acc_q << 3) + (acc_q << 1) + MONTO_W'(digito);
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`ifdef ENTRADA_BORRADO_EN
        ACC_DEL: begin
          if (cnt_q != '0) begin
            acc_d = acc_q / MONTO_W'(10);
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign acc   = acc_q;
  assign sat   = (cnt_q == CNT_W'(MAX_DIGITOS));
  assign vacio = (cnt_q == '0);

endmodule

// File: rtl/entrada_teclado.sv
// Keypad front-end for Cajero. Forwards PIN digits (DIGITO/DIGITO_STB),
// then accumulates a decimal amount and issues MONTO/MONTO_STB on ENTER,
// with TIPO_TRANS latched from the deposit/withdraw keys.
// Inputs : CLK, RESET (sync, high), TARJETA_RECIBIDA, TECLA_STB, TECLA,
//          PIN_INCORRECTO, BLOQUEO.
// Outputs: DIGITO, DIGITO_STB, TIPO_TRANS, MONTO, MONTO_STB (all registered).
// Macro: ENTRADA_BORRADO_EN enables key 0xE as amount backspace.
module entrada_teclado
  import cajero_pkg::*;
#(
  parameter int unsigned MAX_DIGITOS = 9,
  parameter int unsigned PIN_LARGO   = 4
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               TARJETA_RECIBIDA,
  input  logic               TECLA_STB,
  input  logic [TECLA_W-1:0] TECLA,
  input  logic               PIN_INCORRECTO,
  input  logic               BLOQUEO,
  output logic [TECLA_W-1:0] DIGITO,
  output logic               DIGITO_STB,
  output logic               TIPO_TRANS,
  output logic [MONTO_W-1:0] MONTO,
  output logic               MONTO_STB
);

  localparam int unsigned PIN_W = $clog2(PIN_LARGO + 1);

  estado_e            estado_q, estado_d;
  logic [PIN_W-1:0]   pin_cnt_q, pin_cnt_d;
  logic [TECLA_W-1:0] digito_q, digito_d;
  logic               digito_stb_q, digito_stb_d;
  logic               tipo_q, tipo_d;
  logic [MONTO_W-1:0] monto_q, monto_d;
  logic               monto_stb_q, monto_stb_d;

  logic               acc_en;
  acc_op_e            acc_op;
  logic [MONTO_W-1:0] acc_val;
  logic               acc_sat;
  logic               acc_vacio;

  acum_decimal #(
    .MAX_DIGITOS(MAX_DIGITOS)
  ) u_acum (
    .clk   (CLK),
    .rst   (RESET),
    .en    (acc_en),
    .op    (acc_op),
    .digito(TECLA),
    .acc   (acc_val),
    .sat   (acc_sat),
    .vacio (acc_vacio)
  );

  // Next-state / output logic; priority: card removal > BLOQUEO >
  // PIN_INCORRECTO > key (RESET handled in the register).
  always_comb begin
    estado_d     = estado_q;
    pin_cnt_d    = pin_cnt_q;
    digito_d     = digito_q;
    digito_stb_d = 1'b0;
    tipo_d       = tipo_q;
    monto_d      = monto_q;
    monto_stb_d  = 1'b0;
    acc_en       = 1'b0;
    acc_op       = ACC_NOP;

    if (!TARJETA_RECIBIDA) begin
      estado_d  = ST_ESPERA;
      pin_cnt_d = '0;
      tipo_d    = 1'b0;
      monto_d   = '0;
      acc_en    = 1'b1;
      acc_op    = ACC_CLR;
    end else if (BLOQUEO && (estado_q != ST_ESPERA)) begin
      estado_d = ST_BLOQ;
    end else if (PIN_INCORRECTO &&
                 ((estado_q == ST_PIN) || (estado_q == ST_MONTO))) begin
      estado_d  = ST_PIN;
      pin_cnt_d = '0;
      acc_en    = 1'b1;
      acc_op    = ACC_CLR;
    end else begin
      case (estado_q)
        // Card must be seen for a cycle; a key in this cycle is dropped.
        ST_ESPERA: begin
          estado_d  = ST_PIN;
          pin_cnt_d = '0;
        end
        ST_PIN: begin
          if (TECLA_STB && es_digito(TECLA)) begin
            digito_d     = TECLA;
            digito_stb_d = 1'b1;
            pin_cnt_d    = pin_cnt_q + PIN_W'(1);
            if ((pin_cnt_q + PIN_W'(1)) == PIN_W'(PIN_LARGO)) begin
              estado_d = ST_MONTO;
            end
          end
        end
        ST_MONTO: begin
          if (TECLA_STB) begin
            if (es_digito(TECLA)) begin
              if (!acc_sat) begin
                acc_en = 1'b1;
                acc_op = ACC_ADD;
              end
            end else begin
              case (TECLA)
                TECLA_DEP: tipo_d = 1'b0;
                TECLA_RET: tipo_d = 1'b1;
                TECLA_CLEAR: begin
                  acc_en = 1'b1;
                  acc_op = ACC_CLR;
                end
                TECLA_ENTER: begin
                  if (!acc_vacio) begin
                    monto_d     = acc_val;
                    monto_stb_d = 1'b1;
                    estado_d    = ST_HECHO;
                  end
                end
`ifdef ENTRADA_BORRADO_EN
                TECLA_BORRAR: begin
                  if (!acc_vacio) begin
                    acc_en = 1'b1;
                    acc_op = ACC_DEL;
                  end
                end
`endif
                default: ;
              endcase
            end
          end
        end
        ST_HECHO: ;
        ST_BLOQ:  ;
        default:  estado_d = ST_ESPERA;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      estado_q     <= ST_ESPERA;
      pin_cnt_q    <= '0;
      digito_q     <= '0;
      digito_stb_q <= 1'b0;
      tipo_q       <= 1'b0;
      monto_q      <= '0;
      monto_stb_q  <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      pin_cnt_q    <= pin_cnt_d;
      digito_q     <= digito_d;
      digito_stb_q <= digito_stb_d;
      tipo_q       <= tipo_d;
      monto_q      <= monto_d;
      monto_stb_q  <= monto_stb_d;
    end
  end

  assign DIGITO     = digito_q;
  assign DIGITO_STB = digito_stb_q;
  assign TIPO_TRANS = tipo_q;
  assign MONTO      = monto_q;
  assign MONTO_STB  = monto_stb_q;

endmodule

// File: tb/tb_entrada_teclado.sv
// Bench for entrada_teclado: a vector table plus hand-written sequences;
// each driven cycle pushes the expected outputs for the following edge
// to a scoreboard queue, which a monitor pops and compares.
module tb_entrada_teclado;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        TARJETA_RECIBIDA;
  logic        TECLA_STB;
  logic [3:0]  TECLA;
  logic        PIN_INCORRECTO;
  logic        BLOQUEO;
  logic [3:0]  DIGITO;
  logic        DIGITO_STB;
  logic        TIPO_TRANS;
  logic [31:0] MONTO;
  logic        MONTO_STB;

  always #5 CLK = ~CLK;

  entrada_teclado dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .TARJETA_RECIBIDA(TARJETA_RECIBIDA),
    .TECLA_STB       (TECLA_STB),
    .TECLA           (TECLA),
    .PIN_INCORRECTO  (PIN_INCORRECTO),
    .BLOQUEO         (BLOQUEO),
    .DIGITO          (DIGITO),
    .DIGITO_STB      (DIGITO_STB),
    .TIPO_TRANS      (TIPO_TRANS),
    .MONTO           (MONTO),
    .MONTO_STB       (MONTO_STB)
  );

  typedef struct {
    logic        rst;
    logic        card;
    logic        stb;
    logic [3:0]  tecla;
    logic        pinc;
    logic        bloq;
    logic        e_dstb;
    logic [3:0]  e_dig;
    logic        e_mstb;
    logic [31:0] e_monto;
    logic        e_tipo;
  } vec_t;

  typedef struct {
    logic        e_dstb;
    logic [3:0]  e_dig;
    logic        e_mstb;
    logic [31:0] e_monto;
    logic        e_tipo;
    int          id;
  } exp_t;

  exp_t        sb[$];
  vec_t        tv[$];
  int          total = 0;
  int          bad = 0;
  int          step_id = 0;
  logic [31:0] em;
  logic        et;

  function automatic vec_t mk(input logic rst, card, stb, input logic [3:0] tecla,
                              input logic pinc, bloq, dstb, input logic [3:0] dig,
                              input logic mstb, input logic [31:0] monto, input logic tipo);
    vec_t v;
    v.rst = rst; v.card = card; v.stb = stb; v.tecla = tecla;
    v.pinc = pinc; v.bloq = bloq; v.e_dstb = dstb; v.e_dig = dig;
    v.e_mstb = mstb; v.e_monto = monto; v.e_tipo = tipo;
    return v;
  endfunction

  task automatic chk(input string nm, input int id, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s step=%0d got=%0d want=%0d", nm, id, got, want);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue its expected response.
  task automatic step(input logic rst, card, stb, input logic [3:0] tecla,
                      input logic pinc, bloq, e_dstb, input logic [3:0] e_dig,
                      input logic e_mstb, input logic [31:0] e_monto, input logic e_tipo);
    exp_t e;
    @(negedge CLK);
    RESET = rst;
    TARJETA_RECIBIDA = card;
    TECLA_STB = stb;
    TECLA = tecla;
    PIN_INCORRECTO = pinc;
    BLOQUEO = bloq;
    e.e_dstb = e_dstb; e.e_dig = e_dig; e.e_mstb = e_mstb;
    e.e_monto = e_monto; e.e_tipo = e_tipo; e.id = step_id;
    step_id++;
    sb.push_back(e);
  endtask

  task automatic k(input logic [3:0] t, input logic dstb, input logic mstb);
    step(1'b0, 1'b1, 1'b1, t, 1'b0, 1'b0, dstb, t, mstb, em, et);
  endtask

  task automatic idle(input logic card);
    step(1'b0, card, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, em, et);
  endtask

  task automatic insert();
    em = '0; et = 1'b0;
    idle(1'b0);
    idle(1'b1);
  endtask

  task automatic pin4(input logic [3:0] a, b, c, d);
    k(a, 1'b1, 1'b0); k(b, 1'b1, 1'b0); k(c, 1'b1, 1'b0); k(d, 1'b1, 1'b0);
  endtask

  // Monitor: sample 1 time unit after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("digito_stb", e.id, 32'(DIGITO_STB), 32'(e.e_dstb));
        if (e.e_dstb) chk("digito", e.id, 32'(DIGITO), 32'(e.e_dig));
        chk("monto_stb", e.id, 32'(MONTO_STB), 32'(e.e_mstb));
        chk("monto", e.id, MONTO, e.e_monto);
        chk("tipo_trans", e.id, 32'(TIPO_TRANS), 32'(e.e_tipo));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    RESET = 1'b1; TARJETA_RECIBIDA = 1'b0; TECLA_STB = 1'b0; TECLA = 4'h0;
    PIN_INCORRECTO = 1'b0; BLOQUEO = 1'b0;
    em = '0; et = 1'b0;

    //          rst card stb tecla pinc bloq | dstb dig mstb monto tipo
    tv.push_back(mk(1, 0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0,   0));
    tv.push_back(mk(1, 1, 1, 4'h5, 0, 0, 0, 4'h0, 0, 0,   0));
    tv.push_back(mk(0, 1, 1, 4'h7, 0, 0, 0, 4'h0, 0, 0,   0));
    tv.push_back(mk(0, 1, 1, 4'h1, 0, 0, 1, 4'h1, 0, 0,   0));
    tv.push_back(mk(0, 1, 1, 4'h2, 0, 0, 1, 4'h2, 0, 0,   0));
    tv.push_back(mk(0, 1, 1, 4'hA, 0, 0, 0, 4'h0, 0, 0,   0));
    tv.push_back(mk(0, 1, 1, 4'h3, 0, 0, 1, 4'h3, 0, 0,   0));
    tv.push_back(mk(0, 1, 1, 4'h4, 0, 0, 1, 4'h4, 0, 0,   0));
    tv.push_back(mk(0, 1, 1, 4'hD, 0, 0, 0, 4'h0, 0, 0,   1));
    tv.push_back(mk(0, 1, 1, 4'h2, 0, 0, 0, 4'h0, 0, 0,   1));
    tv.push_back(mk(0, 1, 1, 4'h5, 0, 0, 0, 4'h0, 0, 0,   1));
    tv.push_back(mk(0, 1, 1, 4'h0, 0, 0, 0, 4'h0, 0, 0,   1));
    tv.push_back(mk(0, 1, 1, 4'hA, 0, 0, 0, 4'h0, 1, 250, 1));
    tv.push_back(mk(0, 1, 1, 4'h1, 0, 0, 0, 4'h0, 0, 250, 1));
    tv.push_back(mk(0, 0, 1, 4'h1, 0, 0, 0, 4'h0, 0, 0,   0));
    tv.push_back(mk(0, 1, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0,   0));
    tv.push_back(mk(0, 1, 1, 4'h9, 0, 0, 1, 4'h9, 0, 0,   0));
    tv.push_back(mk(0, 1, 1, 4'h8, 0, 0, 1, 4'h8, 0, 0,   0));
    tv.push_back(mk(0, 1, 1, 4'h7, 0, 0, 1, 4'h7, 0, 0,   0));
    tv.push_back(mk(0, 1, 1, 4'h6, 0, 0, 1, 4'h6, 0, 0,   0));
    tv.push_back(mk(0, 1, 1, 4'h1, 0, 0, 0, 4'h0, 0, 0,   0));
    tv.push_back(mk(0, 1, 1, 4'h2, 0, 0, 0, 4'h0, 0, 0,   0));
    tv.push_back(mk(0, 1, 1, 4'h3, 0, 0, 0, 4'h0, 0, 0,   0));
    tv.push_back(mk(0, 1, 1, 4'hB, 0, 0, 0, 4'h0, 0, 0,   0));
    tv.push_back(mk(0, 1, 1, 4'h7, 0, 0, 0, 4'h0, 0, 0,   0));
    tv.push_back(mk(0, 1, 1, 4'hC, 0, 0, 0, 4'h0, 0, 0,   0));
    tv.push_back(mk(0, 1, 1, 4'hD, 0, 0, 0, 4'h0, 0, 0,   1));
    tv.push_back(mk(0, 1, 1, 4'hC, 0, 0, 0, 4'h0, 0, 0,   0));
    tv.push_back(mk(0, 1, 1, 4'hA, 0, 0, 0, 4'h0, 1, 7,   0));
    tv.push_back(mk(0, 1, 1, 4'h5, 1, 0, 0, 4'h0, 0, 7,   0));
    tv.push_back(mk(0, 0, 0, 4'h0, 0, 0, 0, 4'h0, 0, 0,   0));

    for (int i = 0; i < tv.size(); i++) begin
      step(tv[i].rst, tv[i].card, tv[i].stb, tv[i].tecla, tv[i].pinc, tv[i].bloq,
           tv[i].e_dstb, tv[i].e_dig, tv[i].e_mstb, tv[i].e_monto, tv[i].e_tipo);
    end

    // Empty ENTER ignored, twelve 9s saturate at nine digits.
    insert();
    pin4(4'h1, 4'h2, 4'h3, 4'h4);
    k(4'hA, 1'b0, 1'b0);
    et = 1'b1;
    k(4'hD, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) k(4'h9, 1'b0, 1'b0);
    em = 32'd999999999;
    k(4'hA, 1'b0, 1'b1);
    k(4'h5, 1'b0, 1'b0);

    // Backspace key (also pressed on an empty amount first).
    insert();
    pin4(4'h5, 4'h5, 4'h5, 4'h5);
    k(4'hE, 1'b0, 1'b0);
    k(4'h4, 1'b0, 1'b0); k(4'h5, 1'b0, 1'b0); k(4'h6, 1'b0, 1'b0);
    k(4'hE, 1'b0, 1'b0);
`ifdef ENTRADA_BORRADO_EN
    em = 32'd45;
`else
    em = 32'd456;
`endif
    k(4'hA, 1'b0, 1'b1);

    // Wrong PIN mid-amount restarts the PIN and clears the amount.
    insert();
    pin4(4'h1, 4'h2, 4'h3, 4'h4);
    k(4'h3, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 4'h9, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, em, et);
    pin4(4'h5, 4'h6, 4'h7, 4'h8);
    k(4'h2, 1'b0, 1'b0);
    em = 32'd2;
    k(4'hA, 1'b0, 1'b1);

    // BLOQUEO beats PIN_INCORRECTO and key; blocked until card removal.
    insert();
    k(4'h1, 1'b1, 1'b0); k(4'h2, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 4'h3, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, em, et);
    k(4'h4, 1'b0, 1'b0); k(4'h5, 1'b0, 1'b0); k(4'h6, 1'b0, 1'b0); k(4'hA, 1'b0, 1'b0);
    insert();
    k(4'h1, 1'b1, 1'b0);

    // Card removed mid-amount (with a key in that cycle), then reinserted.
    k(4'h2, 1'b1, 1'b0); k(4'h3, 1'b1, 1'b0); k(4'h4, 1'b1, 1'b0);
    et = 1'b1;
    k(4'hD, 1'b0, 1'b0);
    k(4'h3, 1'b0, 1'b0); k(4'h4, 1'b0, 1'b0);
    em = '0; et = 1'b0;
    step(1'b0, 1'b0, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, em, et);
    idle(1'b1);
    k(4'h8, 1'b1, 1'b0);

    // Reset mid-PIN swallows the pending key and restarts the PIN count.
    k(4'h1, 1'b1, 1'b0); k(4'h2, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 4'h4, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, em, et);
    idle(1'b1);
    pin4(4'h4, 4'h5, 4'h6, 4'h7);
    k(4'h1, 1'b0, 1'b0);
    em = 32'd1;
    k(4'hA, 1'b0, 1'b1);

    em = '0; et = 1'b0;
    idle(1'b0);
    @(posedge CLK);
    @(posedge CLK);
    #2;
    chk("scoreboard_drained", step_id, 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
